fifo_uart_tx: RTL

- Downstream consumer of the 16x8 sync FIFO.
- Pops one byte at a time via the FIFO read strobe and transmits it on a serial line as UART 8N1, LSB first.
- Decouples bursty producer writes from a fixed-rate serial output; sits between the FIFO read side and the board TX pin.

---
 rtl/fifo_uart_tx_pkg.sv | 17 +
 rtl/fifo_uart_tx_if.sv | 31 +++
 rtl/fifo_uart_tx_baud_cnt.sv | 30 +++
 rtl/fifo_uart_tx.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_pkg: shared state encoding and default sizing for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  // PARITY is only reachable when FIFO_UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4,
    PARITY = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side view of the sync FIFO as seen by the UART transmitter.
// The transmitter is the master (it issues fifo_rd); the FIFO is the slave.
interface fifo_uart_tx_if
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_dout;

  modport master (
    input  fifo_empty,
    input  fifo_full,
    input  fifo_wr,
    input  fifo_dout,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_full,
    output fifo_wr,
    output fifo_dout,
    input  fifo_rd
  );

endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// uart_baud_cnt: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_done on the
// last cycle of every serial bit. clear holds the count at zero between frames.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running bit-period counter, restarted whenever the FSM is not shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_done = !clear && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a sync FIFO and sends them as UART 8N1, LSB first.
// Optional macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tx_en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt;
  logic              bit_done;
  logic              baud_clear;
  logic              pop_ok;
  logic              last_bit;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  // The FIFO services a write instead of a read when both arrive and it is not full.
  assign pop_ok     = fifo.fifo_rd && !(fifo.fifo_wr && !fifo.fifo_full);
  assign baud_clear = (state == IDLE) || (state == WAIT);
  assign last_bit   = (bit_cnt == LAST_BIT);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one frame per accepted pop, a rejected pop simply retries.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (pop_ok) next_state = WAIT;
      WAIT:  next_state = START;
      START: if (bit_done) next_state = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
      DATA:   if (bit_done && last_bit) next_state = PARITY;
      PARITY: if (bit_done) next_state = STOP;
`else
      DATA:  if (bit_done && last_bit) next_state = STOP;
`endif
      STOP:  if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from the current state; the read strobe is held low during reset.
  always_comb begin
    fifo.fifo_rd = rst && (state == IDLE) && tx_en && !fifo.fifo_empty;
    busy         = (state != IDLE);
  end

  // Datapath: capture the popped byte, shift it out and keep tx registered so it never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx         <= 1'b1;
      shift_reg  <= '0;
      bit_cnt    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT: begin
          shift_reg  <= fifo.fifo_dout;
          bit_cnt    <= '0;
          tx         <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= ^fifo.fifo_dout;
`endif
        end
        START: begin
          if (bit_done) tx <= shift_reg[0];
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            if (last_bit) begin
              bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity_bit;
`else
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= shift_reg[1];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) tx <= 1'b1;
        end
`endif
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
